// File: rtl/ahblite_slaveport_arbiter_if.sv
// Bus bundle between the masterport request side and one slaveport arbiter.
// The slave modport is the arbiter's view; the master modport is the driving side.
interface ahblite_slaveport_arbiter_if #(
  parameter int MASTER = 4,
  parameter int IDX_W  = (MASTER > 1) ? $clog2(MASTER) : 1
);
  logic [MASTER-1:0]      mst_HSEL_i;
  logic [MASTER-1:0][1:0] mst_HTRANS_i;
  logic [MASTER-1:0][2:0] mst_HBURST_i;
  logic [MASTER-1:0]      mst_HMASTLOCK_i;
  logic                   slv_HREADY_i;
  logic [MASTER-1:0]      mst_grant_o;
  logic [MASTER-1:0]      mst_dphase_o;
  logic [IDX_W-1:0]       owner_o;
  logic                   hold_o;

  modport slave (
    input  mst_HSEL_i,
    input  mst_HTRANS_i,
    input  mst_HBURST_i,
    input  mst_HMASTLOCK_i,
    input  slv_HREADY_i,
    output mst_grant_o,
    output mst_dphase_o,
    output owner_o,
    output hold_o
  );

  modport master (
    output mst_HSEL_i,
    output mst_HTRANS_i,
    output mst_HBURST_i,
    output mst_HMASTLOCK_i,
    output slv_HREADY_i,
    input  mst_grant_o,
    input  mst_dphase_o,
    input  owner_o,
    input  hold_o
  );
endinterface

// File: rtl/ahblite_slaveport_arbiter.sv
// Round-robin address-phase arbiter for one AHB-Lite slaveport, with burst/lock
// grant pinning and data-phase owner tracking.
module ahblite_slaveport_arbiter #(
  parameter int MASTER = 4,
  parameter int IDX_W  = (MASTER > 1) ? $clog2(MASTER) : 1
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  ahblite_slaveport_arbiter_if.slave bus
);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  localparam logic [2:0] HB_INCR   = 3'b001;
  localparam logic [2:0] HB_WRAP4  = 3'b010;
  localparam logic [2:0] HB_INCR4  = 3'b011;
  localparam logic [2:0] HB_WRAP8  = 3'b100;
  localparam logic [2:0] HB_INCR8  = 3'b101;
  localparam logic [2:0] HB_WRAP16 = 3'b110;
  localparam logic [2:0] HB_INCR16 = 3'b111;

  function automatic logic [4:0] burst_beats_m1(input logic [2:0] hburst);
    case (hburst)
      HB_INCR4, HB_WRAP4:   burst_beats_m1 = 5'd3;
      HB_INCR8, HB_WRAP8:   burst_beats_m1 = 5'd7;
      HB_INCR16, HB_WRAP16: burst_beats_m1 = 5'd15;
      default:              burst_beats_m1 = 5'd0;
    endcase
  endfunction

  logic [MASTER-1:0] req;
  logic [MASTER-1:0] grant;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              hold_q, hold_d;
  logic [MASTER-1:0] dphase_q, dphase_d;

  logic       own_sel;
  logic       own_lock;
  logic [1:0] own_trans;
  logic [2:0] own_burst;
  logic       acc;
  logic       burst_hold, incr_hold, lock_hold;
  logic       arb_en;

  always_comb begin
    req = '0;
    for (int m = 0; m < MASTER; m++) begin
      req[m] = bus.mst_HSEL_i[m] & bus.mst_HTRANS_i[m][1];
    end
  end

  always_comb begin
    grant = '0;
    grant[owner_q] = 1'b1;
  end

  // Only the current owner's control signals steer counter and hold.
  assign own_sel   = bus.mst_HSEL_i[owner_q];
  assign own_lock  = bus.mst_HMASTLOCK_i[owner_q];
  assign own_trans = bus.mst_HTRANS_i[owner_q];
  assign own_burst = bus.mst_HBURST_i[owner_q];

  // A transfer is accepted when the owner requests (HSEL with NONSEQ/SEQ) and
  // HREADY is high at the same edge; while HREADY is low nothing advances.
  assign acc = bus.slv_HREADY_i & req[owner_q];

  always_comb begin
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    dphase_d   = dphase_q;
    burst_hold = 1'b0;
    incr_hold  = 1'b0;
    lock_hold  = 1'b0;
    if (bus.slv_HREADY_i) begin
      if (acc) begin
        if (own_trans == HT_NONSEQ) begin
          cnt_d = burst_beats_m1(own_burst);
        end else begin
          cnt_d = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
        end
      end else if (!(own_sel && own_trans == HT_BUSY)) begin
        // IDLE (or owner gone) ends the burst early.
        cnt_d = 5'd0;
      end
      burst_hold = (cnt_d != 5'd0);
      incr_hold  = own_sel && (own_burst == HB_INCR) && (own_trans != HT_IDLE);
      lock_hold  = own_lock;
      hold_d     = burst_hold | incr_hold | lock_hold;
      dphase_d   = acc ? grant : '0;
    end
  end

  assign arb_en = bus.slv_HREADY_i & ~hold_d;

  if (MASTER == 1) begin : g_single
    always_comb owner_d = '0;
  end else begin : g_rr
    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan owner+1 .. owner+MASTER so the current owner has lowest priority.
    always_comb begin
      owner_d = owner_q;
      found   = 1'b0;
      cand    = '0;
      if (arb_en) begin
        for (int i = 1; i <= MASTER; i++) begin
          cand = IDX_W'((int'(owner_q) + i) % MASTER);
          if (!found && req[cand]) begin
            owner_d = cand;
            found   = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      owner_q  <= '0;
      cnt_q    <= 5'd0;
      hold_q   <= 1'b0;
      dphase_q <= '0;
    end else begin
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      dphase_q <= dphase_d;
    end
  end

  assign bus.mst_grant_o  = grant;
  assign bus.mst_dphase_o = dphase_q;
  assign bus.owner_o      = owner_q;
  assign bus.hold_o       = hold_q;

endmodule

// File: tb/tb_ahblite_slaveport_arbiter.sv
// Bench for the slaveport arbiter: job-driven masters, a behavioural model that
// predicts owner/hold/data-phase each edge, and a negedge scoreboard monitor.
module tb_ahblite_slaveport_arbiter;
  localparam int MASTER = 4;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  localparam logic [2:0] HB_SINGLE = 3'd0;
  localparam logic [2:0] HB_INCR   = 3'd1;
  localparam logic [2:0] HB_INCR4  = 3'd3;
  localparam logic [2:0] HB_INCR8  = 3'd5;
  localparam logic [2:0] HB_INCR16 = 3'd7;

  // ---------------- clock / reset ----------------
  logic HCLK   = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  ahblite_slaveport_arbiter_if #(.MASTER(MASTER)) bus ();

  ahblite_slaveport_arbiter #(.MASTER(MASTER)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];  // {grant[3:0], dphase[3:0], owner[1:0], hold}
  logic [10:0] mon_e;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge HCLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("grant",  bus.mst_grant_o,          mon_e[10:7]);
      check("dphase", bus.mst_dphase_o,         mon_e[6:3]);
      check("owner",  {2'b00, bus.owner_o},     {2'b00, mon_e[2:1]});
      check("hold",   {3'b000, bus.hold_o},     {3'b000, mon_e[0]});
    end
  end

  // ---------------- reference model ----------------
  int   m_owner = 0;
  int   m_cnt   = 0;
  bit   m_hold  = 1'b0;
  logic [3:0] m_dphase = 4'b0;
  int   burst_len [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  // ---------------- masters (one job each) ----------------
  bit         j_act   [MASTER];
  bit         j_first [MASTER];
  bit         j_lock  [MASTER];
  int         j_left  [MASTER];
  logic [2:0] j_burst [MASTER];
  bit         rand_busy = 1'b0;

  task automatic start_job(input int m, input logic [2:0] b, input int n, input bit lk);
    j_act[m]   = 1'b1;
    j_first[m] = 1'b1;
    j_lock[m]  = lk;
    j_left[m]  = n;
    j_burst[m] = b;
  endtask

  task automatic step(input bit hr, input bit rst);
    logic [MASTER-1:0] sel, lk, rq;
    logic [1:0] tr [MASTER];
    logic [2:0] bu [MASTER];
    int  own;
    bit  acc, inc;
    for (int m = 0; m < MASTER; m++) begin
      if (j_act[m]) begin
        sel[m] = 1'b1;
        bu[m]  = j_burst[m];
        lk[m]  = j_lock[m];
        if (j_first[m] || j_burst[m] == HB_SINGLE) tr[m] = HT_NONSEQ;
        else if (rand_busy && $urandom_range(0, 99) < 15) tr[m] = HT_BUSY;
        else tr[m] = HT_SEQ;
      end else begin
        sel[m] = 1'b0;
        tr[m]  = HT_IDLE;
        bu[m]  = HB_SINGLE;
        lk[m]  = 1'b0;
      end
      rq[m] = sel[m] && (tr[m] == HT_NONSEQ || tr[m] == HT_SEQ);
    end
    bus.mst_HSEL_i      = sel;
    bus.mst_HMASTLOCK_i = lk;
    for (int m = 0; m < MASTER; m++) begin
      bus.mst_HTRANS_i[m] = tr[m];
      bus.mst_HBURST_i[m] = bu[m];
    end
    bus.slv_HREADY_i = hr;
    HRESET = rst;
    @(posedge HCLK);
    own = m_owner;
    acc = hr && rq[own];
    if (rst) begin
      m_owner = 0; m_cnt = 0; m_hold = 1'b0; m_dphase = 4'b0;
      for (int m = 0; m < MASTER; m++) j_act[m] = 1'b0;
    end else if (hr) begin
      if (acc && tr[own] == HT_NONSEQ) m_cnt = burst_len[bu[own]] - 1;
      else if (acc) m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
      else if (!(sel[own] && tr[own] == HT_BUSY)) m_cnt = 0;
      inc      = sel[own] && bu[own] == HB_INCR && tr[own] != HT_IDLE;
      m_hold   = (m_cnt != 0) || inc || lk[own];
      m_dphase = acc ? 4'(1 << own) : 4'b0;
      if (!m_hold) begin
        for (int k = 1; k <= MASTER; k++) begin
          if (rq[(own + k) % MASTER]) begin
            m_owner = (own + k) % MASTER;
            break;
          end
        end
      end
      if (acc) begin
        j_first[own] = 1'b0;
        j_left[own]--;
        if (j_left[own] == 0) j_act[own] = 1'b0;
      end
    end
    exp_q.push_back({4'(1 << m_owner), m_dphase, 2'(m_owner), m_hold});
    #1;
  endtask

  task automatic run(input int n, input logic [31:0] mask);
    for (int i = 0; i < n; i++) step(mask[i % 32], 1'b0);
  endtask

  task automatic random_job(input int m);
    logic [2:0] b;
    int n;
    bit lk;
    b  = 3'($urandom_range(0, 7));
    lk = 1'b0;
    if (b == HB_SINGLE) begin
      n = 1;
      if ($urandom_range(0, 99) < 25) begin
        lk = 1'b1;
        n  = $urandom_range(2, 4);
      end
    end else if (b == HB_INCR) begin
      n = $urandom_range(1, 6);
    end else begin
      n = burst_len[b];
      if ($urandom_range(0, 99) < 15) n = $urandom_range(1, n - 1);
    end
    start_job(m, b, n, lk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int m = 0; m < MASTER; m++) j_act[m] = 1'b0;
    bus.mst_HSEL_i      = '0;
    bus.mst_HTRANS_i    = '0;
    bus.mst_HBURST_i    = '0;
    bus.mst_HMASTLOCK_i = '0;
    bus.slv_HREADY_i    = 1'b1;

    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // single request from m2
    start_job(2, HB_SINGLE, 1, 1'b0);
    run(4, '1);

    // m0/m1 alternate
    start_job(0, HB_SINGLE, 4, 1'b0);
    start_job(1, HB_SINGLE, 4, 1'b0);
    run(10, '1);

    // INCR4 on m1 with wait states, m3 waiting
    start_job(1, HB_INCR4, 4, 1'b0);
    start_job(3, HB_SINGLE, 1, 1'b0);
    run(12, ~32'h0000_000C);

    // locked sequence on m0, m2 waiting
    start_job(0, HB_SINGLE, 3, 1'b1);
    run(1, '1);
    start_job(2, HB_SINGLE, 1, 1'b0);
    run(10, '1);

    // INCR8 cut short after 3 beats, m0 waiting
    start_job(3, HB_INCR8, 3, 1'b0);
    start_job(0, HB_SINGLE, 1, 1'b0);
    run(10, '1);

    // undefined-length INCR
    start_job(1, HB_INCR, 5, 1'b0);
    start_job(2, HB_SINGLE, 1, 1'b0);
    run(10, 32'hFFFF_FFDB);

    // reset in the middle of INCR16
    start_job(0, HB_INCR16, 16, 1'b0);
    run(6, '1);
    step(1'b1, 1'b1);
    run(3, '1);

    // randomized traffic
    rand_busy = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < MASTER; m++) begin
        if (!j_act[m] && $urandom_range(0, 99) < 20) random_job(m);
        else if (j_act[m] && j_first[m] && m != m_owner && $urandom_range(0, 99) < 5)
          j_act[m] = 1'b0;
      end
      step($urandom_range(0, 99) < 75, $urandom_range(0, 999) < 3);
    end
    run(40, '1);

    repeat (2) @(negedge HCLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
